// File: rtl/jarvis_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : jarvis_muldiv_sequencer
// Purpose  : Iterative 32-bit unsigned multiply / divide / modulo sequencer.
//            MULT uses one shift-add step per cycle and DIV/MOD use one
//            restoring-division step per cycle, 32 steps per operation.
//            A zero divisor skips the iterations and finishes at once.
// Ports    : clock        - rising-edge clock
//            reset        - asynchronous active-low reset
//            start        - request an operation (sampled only in IDLE)
//            abort        - cancel an operation in MUL/DIV
//            ALU_Control  - 2 = MULT, 3 = DIV, 4 = MOD, others ignored
//            op_a, op_b   - unsigned operands (latched on acceptance)
//            busy         - operation in progress, including the done cycle
//            done         - one-cycle pulse, result valid
//            result       - low product / quotient / remainder, held
//            div_by_zero  - DIV/MOD with op_b = 0, held with result
// Revision : 1.0 - initial release
// ============================================================================
module jarvis_muldiv_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  ALU_Control,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero
);

  localparam logic [4:0] CODE_MULT = 5'd2;
  localparam logic [4:0] CODE_DIV  = 5'd3;
  localparam logic [4:0] CODE_MOD  = 5'd4;
  localparam logic [5:0] LAST_ITER = 6'd31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  count;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic        is_mod;
  // MUL: {partial product high, multiplier shifting out at the bottom}
  // DIV: {remainder, dividend shifting out / quotient shifting in}
  logic [63:0] acc;

  logic        valid_code;
  logic        accept;
  logic        iterate;
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] acc_next;

  assign valid_code = (ALU_Control == CODE_MULT) || (ALU_Control == CODE_DIV) ||
                      (ALU_Control == CODE_MOD);
  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  // Next-state logic; abort outranks a simultaneous start in IDLE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    iterate    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort && valid_code) begin
          accept = 1'b1;
          if (ALU_Control == CODE_MULT) begin
            state_next = MUL;
          end else if (op_b == 32'd0) begin
            state_next = FINISH;
          end else begin
            state_next = DIV;
          end
        end
      end
      MUL, DIV: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          iterate = 1'b1;
          if (count == LAST_ITER) begin
            state_next = FINISH;
          end
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shift-add step: add multiplicand to the high half when the current
  // multiplier bit is set, then shift the 65-bit {carry, acc} right by one.
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_reg} : 33'd0);

  // Restoring step: the shifted remainder can need 33 bits when the divisor
  // exceeds 2^31. Bit 32 of the difference is the borrow: a successful
  // subtraction always leaves a value below the divisor, so it is clear.
  assign div_trial = acc[63:31];
  assign div_diff  = div_trial - {1'b0, b_reg};
  assign div_ge    = ~div_diff[32];

  always_comb begin
    acc_next = acc;
    if (state == MUL) begin
      acc_next = {mul_sum, acc[31:1]};
    end else if (state == DIV) begin
      acc_next = {(div_ge ? div_diff[31:0] : div_trial[31:0]), acc[30:0], div_ge};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count       <= 6'd0;
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      is_mod      <= 1'b0;
      acc         <= 64'd0;
      result      <= 32'd0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      a_reg  <= op_a;
      b_reg  <= op_b;
      is_mod <= (ALU_Control == CODE_MOD);
      count  <= 6'd0;
      acc    <= (ALU_Control == CODE_MULT) ? {32'd0, op_b} : {32'd0, op_a};
      // Zero divisor goes straight to FINISH, so the result is set here.
      if (ALU_Control != CODE_MULT && op_b == 32'd0) begin
        result      <= (ALU_Control == CODE_DIV) ? 32'hFFFF_FFFF : op_a;
        div_by_zero <= 1'b1;
      end
    end else if (iterate) begin
      acc <= acc_next;
      if (count == LAST_ITER) begin
        count       <= 6'd0;
        result      <= (state == DIV && is_mod) ? acc_next[63:32] : acc_next[31:0];
        div_by_zero <= 1'b0;
      end else begin
        count <= count + 6'd1;
      end
    end else begin
      count <= 6'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jarvis_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jarvis_muldiv_sequencer
// Purpose  : Self-checking bench for jarvis_muldiv_sequencer. Directed
//            vectors from a table, random operations against an arithmetic
//            reference model, and hand-written abort / reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jarvis_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  ALU_Control;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_res;

  jarvis_muldiv_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .ALU_Control (ALU_Control),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic with the zero-divisor rules.
  task automatic model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic dbz);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    dbz  = 1'b0;
    res  = 32'd0;
    case (code)
      5'd2: res = prod[31:0];
      5'd3: begin
        if (b == 0) begin res = 32'hFFFF_FFFF; dbz = 1'b1; end
        else res = a / b;
      end
      5'd4: begin
        if (b == 0) begin res = a; dbz = 1'b1; end
        else res = a % b;
      end
      default: res = 32'd0;
    endcase
  endtask

  // Called right after a negedge with the DUT idle (cycle N). Checks busy
  // and done on every cycle through N+lat+1, while scrambling the inputs
  // (ignored starts, changing operands) and asserting start in the done cycle.
  task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] exp_res;
    logic        exp_dbz;
    int          lat;
    model(code, a, b, exp_res, exp_dbz);
    lat = exp_dbz ? 1 : 33;
    check({tag, " busy before start"}, {31'd0, busy}, 32'd0);
    start = 1'b1; abort = 1'b0; ALU_Control = code; op_a = a; op_b = b;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clock);
      check($sformatf("%s busy cycle N+%0d", tag, k), {31'd0, busy}, 32'd1);
      check($sformatf("%s done cycle N+%0d", tag, k), {31'd0, done}, {31'd0, (k == lat)});
      if (k == lat) begin
        check({tag, " result"}, result, exp_res);
        check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
      end
      start       = (k == lat) ? 1'b1 : 1'($urandom_range(0, 1));
      ALU_Control = 5'($urandom_range(2, 4));
      op_a        = $urandom;
      op_b        = $urandom;
    end
    @(negedge clock);
    check({tag, " busy after done"}, {31'd0, busy}, 32'd0);
    check({tag, " done after done"}, {31'd0, done}, 32'd0);
    check({tag, " result held"}, result, exp_res);
    start    = 1'b0;
    last_res = exp_res;
  endtask

  initial begin
    logic [4:0]  rcode;
    logic [31:0] ra, rb;
    logic        saw_done;
    logic [4:0]  bad_codes[5];

    vecs[0] = '{5'd2, 32'd7,          32'd6,          32'd42,         1'b0};
    vecs[1] = '{5'd2, 32'h0001_0000,  32'h0001_0001,  32'h0001_0000,  1'b0};
    vecs[2] = '{5'd3, 32'd100,        32'd7,          32'd14,         1'b0};
    vecs[3] = '{5'd4, 32'd100,        32'd7,          32'd2,          1'b0};
    vecs[4] = '{5'd3, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[5] = '{5'd4, 32'd5,          32'd0,          32'd5,          1'b1};
    vecs[6] = '{5'd3, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          1'b0};
    vecs[7] = '{5'd4, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  1'b0};
    vecs[8] = '{5'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0};
    vecs[9] = '{5'd4, 32'd3,          32'd10,         32'd3,          1'b0};
    bad_codes[0] = 5'd0; bad_codes[1] = 5'd1; bad_codes[2] = 5'd5;
    bad_codes[3] = 5'd9; bad_codes[4] = 5'd31;

    reset = 1'b0; start = 1'b0; abort = 1'b0; ALU_Control = 5'd0;
    op_a = 32'd0; op_b = 32'd0; last_res = 32'd0;

    @(negedge clock);
    @(negedge clock);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // First start right after reset release, then the directed table.
    for (int i = 0; i < 10; i++) begin
      logic [31:0] mres;
      logic        mdbz;
      model(vecs[i].code, vecs[i].a, vecs[i].b, mres, mdbz);
      check($sformatf("table[%0d] model", i), mres, vecs[i].exp_res);
      run_op(vecs[i].code, vecs[i].a, vecs[i].b, $sformatf("table[%0d]", i));
    end

    // Unsupported codes are ignored in IDLE.
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; ALU_Control = bad_codes[i]; op_a = $urandom; op_b = $urandom;
      @(negedge clock);
      check($sformatf("bad code %0d busy", bad_codes[i]), {31'd0, busy}, 32'd0);
      check($sformatf("bad code %0d result", bad_codes[i]), result, last_res);
      start = 1'b0;
    end

    // abort with start in IDLE: abort wins.
    start = 1'b1; abort = 1'b1; ALU_Control = 5'd2; op_a = 32'd9; op_b = 32'd9;
    @(negedge clock);
    check("abort+start idle busy", {31'd0, busy}, 32'd0);
    start = 1'b0; abort = 1'b0;

    // Randomized operations against the model.
    for (int i = 0; i < 24; i++) begin
      rcode = 5'($urandom_range(2, 4));
      ra    = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op(rcode, ra, rb, $sformatf("rand[%0d] code=%0d a=%h b=%h", i, rcode, ra, rb));
    end

    // Abort of a MULT in cycle N+10, with starts offered in N+1..N+9.
    start = 1'b1; ALU_Control = 5'd2; op_a = 32'd3; op_b = 32'd5;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      check($sformatf("abort seq busy N+%0d", k), {31'd0, busy}, 32'd1);
      start = (k < 10); ALU_Control = 5'd3; op_a = $urandom; op_b = $urandom;
      abort = (k == 10);
    end
    @(negedge clock);
    check("abort seq busy N+11", {31'd0, busy}, 32'd0);
    check("abort seq result held", result, last_res);
    abort = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      saw_done = saw_done | done | busy;
    end
    check("abort seq no done/busy afterwards", {31'd0, saw_done}, 32'd0);

    // Reset low in cycle N+20 of a DIV.
    start = 1'b1; ALU_Control = 5'd3; op_a = 32'd1000; op_b = 32'd3;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      start = 1'b0;
    end
    check("reset seq busy before", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("reset seq busy", {31'd0, busy}, 32'd0);
    check("reset seq done", {31'd0, done}, 32'd0);
    check("reset seq result", result, 32'd0);
    check("reset seq div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b1; start = 1'b1; ALU_Control = 5'd9;
    @(negedge clock);
    check("reset seq code 9 busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    last_res = 32'd0;

    // Start honoured on the first edge after another reset release.
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    run_op(5'd2, 32'd7, 32'd6, "post-reset mult");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jarvis_muldiv_sequencer.md
JARVIS_MULDIV_SEQUENCER -- requirements
Module: jarvis_muldiv_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of an operation in progress.
REQ-006 ALU_Control  input  5  operation code: 2 = MULT, 3 = DIV, 4 = MOD; any other code is ignored.
REQ-007 op_a  input  32  multiplicand or dividend, unsigned.
REQ-008 op_b  input  32  multiplier or divisor, unsigned.
REQ-009 busy  output  1  high while an accepted operation is in progress, including its done cycle.
REQ-010 done  output  1  single-cycle pulse; result is valid in this cycle.
REQ-011 result  output  32  low product, quotient or remainder; held until the next done pulse.
REQ-012 div_by_zero  output  1  set with done when DIV or MOD had op_b = 0; held until the next done pulse.

Function
REQ-013 States SHALL be IDLE, MUL, DIV and FINISH, with a 6-bit iteration counter.
REQ-014 Acceptance: in IDLE, a clock edge with start=1 and ALU_Control in {2,3,4} SHALL latch op_a, op_b and the code.
- Code 2: go to MUL.
- Code 3 or 4 with op_b != 0: go to DIV.
- Code 3 or 4 with op_b = 0: go to FINISH.
REQ-015 In IDLE, start with any other code SHALL leave the state in IDLE, with busy, done and result unchanged.
REQ-016 MUL SHALL perform one shift-add iteration per cycle over 32 iterations into a 64-bit accumulator; result = accumulator[31:0].
REQ-017 DIV SHALL perform one restoring-division iteration per cycle over 32 iterations.
- Code 3: result = quotient.
- Code 4: result = remainder.
REQ-018 After the 32nd iteration edge, the state SHALL go to FINISH.
REQ-019 Latency: if start is accepted at the edge ending cycle N, busy=1 in cycles N+1..N+33 and done=1 only in cycle N+33; the state SHALL return to IDLE, busy=0, in cycle N+34.
REQ-020 Divide by zero: busy=1 and done=1 in cycle N+1, div_by_zero=1, and result SHALL be:
- DIV: 0xFFFFFFFF.
- MOD: op_a.
REQ-021 For a non-zero divisor, or for MULT, div_by_zero SHALL be 0 with done.
REQ-022 result and div_by_zero SHALL update only on the edge that enters FINISH.
REQ-023 In IDLE, the latched operands SHALL NOT change unless start is accepted; changes on op_a/op_b after acceptance SHALL have no effect.
REQ-024 start while busy=1 SHALL be ignored and SHALL NOT queue a request.
REQ-025 abort=1 in MUL or DIV SHALL return to IDLE on that edge: busy=0 next cycle, no done, result and div_by_zero unchanged.
REQ-026 abort in FINISH SHALL be ignored, so done still pulses.
REQ-027 abort=1 together with start=1 in IDLE: abort SHALL take priority and the request SHALL NOT be accepted.
REQ-028 Back-to-back operation: start asserted in the FINISH cycle SHALL be ignored; a new start is accepted no earlier than cycle N+34.
REQ-029 The iteration counter SHALL count 0..31 without wrap; reaching 31 forces the FINISH transition.

Reset
REQ-030 On reset low, the block SHALL immediately enter IDLE and set busy=0, done=0, result=0, div_by_zero=0 and the counter to 0, including in the middle of an operation.
REQ-031 After reset deassertion, the first start SHALL be honoured on the first rising edge.

Verification
REQ-032 MULT: op_a=7, op_b=6, start in cycle N -> done in cycle N+33, result=42, div_by_zero=0, busy low in cycle N+34.
REQ-033 MULT overflow: op_a=0x00010000, op_b=0x00010001 -> result=0x00010000 (low 32 bits of the product).
REQ-034 DIV then MOD: op_a=100, op_b=7 -> DIV result=14; MOD run started in cycle N+34 -> result=2; each done is exactly 33 cycles after its start.
REQ-035 Divide by zero: DIV op_a=5, op_b=0 -> done in cycle N+1, result=0xFFFFFFFF, div_by_zero=1; MOD op_a=5, op_b=0 -> result=5.
REQ-036 abort in cycle N+10 of a MULT -> busy=0 in cycle N+11, no done pulse, result still holds the previous value; start asserted during cycles N+1..N+9 had no effect.
REQ-037 reset low in cycle N+20 of a DIV -> all outputs 0 immediately; start=1 with code 9 afterwards -> busy stays 0.
